// File: rtl/in_service_register.sv
// rtl/in_service_register.sv - 8259A-style in-service register with EOI handling and vector output
module in_service_register (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] toSet,
  input  logic       readPriority,
  input  logic       readIsr,
  input  logic       sendVector,
  input  logic [2:0] zeroLevelIndex,
  input  logic [7:0] ICW2,
  input  logic [7:0] ICW4,
  input  logic       secondACK,
  input  logic       changeInOCW2,
  input  logic [7:0] OCW2,
  output logic [2:0] INTIndex,
  output logic [7:0] dataBuffer,
  output logic [7:0] isrRegValue,
  output logic [2:0] resetedIndex,
  output logic       sendVectorAck,
  output logic       readPriorityAck
);

  logic [7:0] isr_q, isr_d;
  logic [7:0] data_q, data_d;
  logic [2:0] reseted_q, reseted_d;
  logic       sv_ack_q, sv_ack_d;
  logic       rp_ack_q, rp_ack_d;
  logic       aeoi_pend_q, aeoi_pend_d;
  logic       rp_prev_q, rp_prev_d;
  logic       ri_prev_q, ri_prev_d;
  logic       sv_prev_q, sv_prev_d;
  logic       sa_prev_q, sa_prev_d;
  logic       co_prev_q, co_prev_d;

  logic       rp_edge, ri_edge, sv_edge, sa_edge, co_edge;
  logic [2:0] int_index;
  logic [2:0] scan_idx;
  logic       found;
  logic [7:0] set_mask, clr_mask;

  logic unused_bits;
  assign unused_bits = ^{ICW4[7:2], ICW4[0], ICW2[2:0], OCW2[4:3]};

  assign rp_edge = readPriority & ~rp_prev_q;
  assign ri_edge = readIsr      & ~ri_prev_q;
  assign sv_edge = sendVector   & ~sv_prev_q;
  assign sa_edge = secondACK    & ~sa_prev_q;
  assign co_edge = changeInOCW2 & ~co_prev_q;

  // Circular priority search over the registered ISR, starting at the rotation base
  always_comb begin
    int_index = 3'd7;
    found     = 1'b0;
    scan_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = zeroLevelIndex + 3'(i);
      if (!found && isr_q[scan_idx]) begin
        int_index = scan_idx;
        found     = 1'b1;
      end
    end
  end

  // Next-state: set from INTA, clears from AEOI/OCW2 (clear wins), data buffer and acks
  always_comb begin
    set_mask    = rp_edge ? (8'd1 << toSet) : 8'd0;
    clr_mask    = 8'd0;
    reseted_d   = reseted_q;
    aeoi_pend_d = 1'b0;

    // Deferred AEOI: the set landed last cycle, so the current winner is the one to retire
    if (aeoi_pend_q && (isr_q != 8'd0)) begin
      clr_mask  = clr_mask | (8'd1 << int_index);
      reseted_d = int_index;
    end

    if (sa_edge && ICW4[1]) begin
      if (rp_edge) begin
        aeoi_pend_d = 1'b1;
      end else if (isr_q != 8'd0) begin
        clr_mask  = clr_mask | (8'd1 << int_index);
        reseted_d = int_index;
      end
    end

    // OCW2: EOI bit selects a clear; SL chooses specific level versus current winner
    if (co_edge && OCW2[5]) begin
      if (OCW2[6]) begin
        clr_mask  = clr_mask | (8'd1 << OCW2[2:0]);
        reseted_d = OCW2[2:0];
      end else if (isr_q != 8'd0) begin
        clr_mask  = clr_mask | (8'd1 << int_index);
        reseted_d = int_index;
      end
    end

    isr_d = (isr_q & ~clr_mask) | (set_mask & ~clr_mask);

    data_d = data_q;
    if (sv_edge) begin
      data_d = {ICW2[7:3], int_index};
    end else if (ri_edge) begin
      data_d = isr_q;
    end

    sv_ack_d  = sv_edge;
    rp_ack_d  = rp_edge;
    rp_prev_d = readPriority;
    ri_prev_d = readIsr;
    sv_prev_d = sendVector;
    sa_prev_d = secondACK;
    co_prev_d = changeInOCW2;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      isr_q       <= 8'd0;
      data_q      <= 8'd0;
      reseted_q   <= 3'd0;
      sv_ack_q    <= 1'b0;
      rp_ack_q    <= 1'b0;
      aeoi_pend_q <= 1'b0;
      rp_prev_q   <= 1'b0;
      ri_prev_q   <= 1'b0;
      sv_prev_q   <= 1'b0;
      sa_prev_q   <= 1'b0;
      co_prev_q   <= 1'b0;
    end else begin
      isr_q       <= isr_d;
      data_q      <= data_d;
      reseted_q   <= reseted_d;
      sv_ack_q    <= sv_ack_d;
      rp_ack_q    <= rp_ack_d;
      aeoi_pend_q <= aeoi_pend_d;
      rp_prev_q   <= rp_prev_d;
      ri_prev_q   <= ri_prev_d;
      sv_prev_q   <= sv_prev_d;
      sa_prev_q   <= sa_prev_d;
      co_prev_q   <= co_prev_d;
    end
  end

  assign INTIndex        = int_index;
  assign dataBuffer      = data_q;
  assign isrRegValue     = isr_q;
  assign resetedIndex    = reseted_q;
  assign sendVectorAck   = sv_ack_q;
  assign readPriorityAck = rp_ack_q;

endmodule

// File: tb/tb_in_service_register.sv
// tb/tb_in_service_register.sv - scoreboard bench for in_service_register against a reference model
module tb_in_service_register;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] toSet, zeroLevelIndex;
  logic       readPriority, readIsr, sendVector, secondACK, changeInOCW2;
  logic [7:0] ICW2, ICW4, OCW2;
  logic [2:0] INTIndex, resetedIndex;
  logic [7:0] dataBuffer, isrRegValue;
  logic       sendVectorAck, readPriorityAck;

  in_service_register dut (
    .clk(clk), .reset(reset), .toSet(toSet), .readPriority(readPriority),
    .readIsr(readIsr), .sendVector(sendVector), .zeroLevelIndex(zeroLevelIndex),
    .ICW2(ICW2), .ICW4(ICW4), .secondACK(secondACK), .changeInOCW2(changeInOCW2),
    .OCW2(OCW2), .INTIndex(INTIndex), .dataBuffer(dataBuffer),
    .isrRegValue(isrRegValue), .resetedIndex(resetedIndex),
    .sendVectorAck(sendVectorAck), .readPriorityAck(readPriorityAck)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] isr;
    logic [7:0] data;
    logic [2:0] intidx;
    logic [2:0] ridx;
    logic       sva;
    logic       rpa;
  } exp_t;

  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;

  // shadow inputs, applied at the falling edge by step()
  logic       s_rst, s_rp, s_ri, s_sv, s_sa, s_co;
  logic [2:0] s_toset, s_zero;
  logic [7:0] s_icw2, s_icw4, s_ocw2;

  // reference model state
  bit   m_isr [8];
  int   m_data, m_ridx;
  bit   m_pend;
  bit   p_rp, p_ri, p_sv, p_sa, p_co;

  function automatic int winner(int zero);
    for (int k = 0; k < 8; k++) begin
      if (m_isr[(zero + k) % 8]) return (zero + k) % 8;
    end
    return 7;
  endfunction

  function automatic int isr_byte();
    int v = 0;
    for (int k = 0; k < 8; k++) if (m_isr[k]) v += (1 << k);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_cycle(output exp_t e);
    bit e_rp, e_ri, e_sv, e_sa, e_co;
    bit clr [8];
    int w, old_isr, z;
    bit new_pend;
    z = int'(s_zero);
    if (s_rst) begin
      for (int k = 0; k < 8; k++) m_isr[k] = 0;
      m_data = 0; m_ridx = 0; m_pend = 0;
      p_rp = 0; p_ri = 0; p_sv = 0; p_sa = 0; p_co = 0;
      e.isr = 8'h00; e.data = 8'h00; e.intidx = 3'd7; e.ridx = 3'd0;
      e.sva = 1'b0; e.rpa = 1'b0;
      return;
    end
    e_rp = s_rp && !p_rp; e_ri = s_ri && !p_ri; e_sv = s_sv && !p_sv;
    e_sa = s_sa && !p_sa; e_co = s_co && !p_co;
    p_rp = s_rp; p_ri = s_ri; p_sv = s_sv; p_sa = s_sa; p_co = s_co;
    w = winner(z);
    old_isr = isr_byte();
    for (int k = 0; k < 8; k++) clr[k] = 0;
    new_pend = 0;
    if (m_pend && old_isr != 0) begin clr[w] = 1; m_ridx = w; end
    if (e_sa && s_icw4[1]) begin
      if (e_rp) new_pend = 1;
      else if (old_isr != 0) begin clr[w] = 1; m_ridx = w; end
    end
    if (e_co) begin
      case (s_ocw2[7:5])
        3'b001, 3'b101: if (old_isr != 0) begin clr[w] = 1; m_ridx = w; end
        3'b011, 3'b111: begin clr[int'(s_ocw2[2:0])] = 1; m_ridx = int'(s_ocw2[2:0]); end
        default: ;
      endcase
    end
    m_pend = new_pend;
    if (e_sv) m_data = int'(s_icw2[7:3]) * 8 + w;
    else if (e_ri) m_data = old_isr;
    if (e_rp) m_isr[int'(s_toset)] = 1;
    for (int k = 0; k < 8; k++) if (clr[k]) m_isr[k] = 0;
    e.isr = 8'(isr_byte()); e.data = 8'(m_data); e.intidx = 3'(winner(z));
    e.ridx = 3'(m_ridx); e.sva = e_sv; e.rpa = e_rp;
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    reset = s_rst; toSet = s_toset; zeroLevelIndex = s_zero;
    readPriority = s_rp; readIsr = s_ri; sendVector = s_sv;
    secondACK = s_sa; changeInOCW2 = s_co;
    ICW2 = s_icw2; ICW4 = s_icw4; OCW2 = s_ocw2;
    model_cycle(e);
    exp_q.push_back(e);
  endtask

  task automatic pulse_set(input int idx);
    s_toset = 3'(idx); s_rp = 1; step(); s_rp = 0; step();
  endtask

  task automatic ocw2_cmd(input logic [7:0] v);
    s_ocw2 = v; s_co = 1; step(); s_co = 0; step();
  endtask

  // monitor: every cycle the DUT presents a full output set; compare to the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("isrRegValue", int'(isrRegValue), int'(e.isr));
        chk("dataBuffer", int'(dataBuffer), int'(e.data));
        chk("INTIndex", int'(INTIndex), int'(e.intidx));
        chk("resetedIndex", int'(resetedIndex), int'(e.ridx));
        chk("sendVectorAck", int'(sendVectorAck), int'(e.sva));
        chk("readPriorityAck", int'(readPriorityAck), int'(e.rpa));
      end
    end
  end

  initial begin
    reset = 1'b1; toSet = 0; zeroLevelIndex = 0; readPriority = 0; readIsr = 0;
    sendVector = 0; secondACK = 0; changeInOCW2 = 0; ICW2 = 0; ICW4 = 0; OCW2 = 0;
    s_rst = 1; s_rp = 0; s_ri = 0; s_sv = 0; s_sa = 0; s_co = 0;
    s_toset = 0; s_zero = 0; s_icw2 = 0; s_icw4 = 0; s_ocw2 = 0;
    step(); step();
    s_rst = 0; step(); step();

    // AEOI with coincident set: bit 3 visible for one cycle, cleared the next
    s_icw4 = 8'hEE; s_zero = 0; s_toset = 3; s_rp = 1; s_sa = 1; step();
    s_rp = 0; s_sa = 0; step(); step();

    // circular priority wrap
    s_icw4 = 8'h00;
    pulse_set(1); pulse_set(5);
    s_zero = 4; step(); s_zero = 6; step();

    // empty ISR vector is IR7
    ocw2_cmd(8'h61); ocw2_cmd(8'h65);
    s_icw2 = 8'hED; s_sv = 1; step(); s_sv = 0; step(); step();

    // specific then non-specific EOI
    s_zero = 0;
    pulse_set(3); pulse_set(5);
    ocw2_cmd(8'h63); ocw2_cmd(8'h20);

    // vector beats ISR read, then ISR read alone, then specific EOI on empty ISR
    pulse_set(1); pulse_set(3);
    s_ri = 1; s_sv = 1; step(); s_ri = 0; s_sv = 0; step();
    s_ri = 1; step(); s_ri = 0; step();
    ocw2_cmd(8'hE3); ocw2_cmd(8'hE9); ocw2_cmd(8'hE9);

    // randomized traffic with occasional mid-run reset
    for (int n = 0; n < 2000; n++) begin
      s_rst   = ($urandom_range(0, 149) == 0);
      s_rp    = ($urandom_range(0, 2) == 0);
      s_ri    = ($urandom_range(0, 3) == 0);
      s_sv    = ($urandom_range(0, 3) == 0);
      s_sa    = ($urandom_range(0, 2) == 0);
      s_co    = ($urandom_range(0, 3) == 0);
      s_toset = 3'($urandom_range(0, 7));
      s_zero  = 3'($urandom_range(0, 7));
      s_icw2  = 8'($urandom_range(0, 255));
      s_ocw2  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 31) == 0) s_icw4 = 8'($urandom_range(0, 255));
      step();
    end
    s_rst = 0; s_rp = 0; s_ri = 0; s_sv = 0; s_sa = 0; s_co = 0;
    step();

    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
